// File: rtl/bp_update_unit_pkg.sv
// Shared types for the branch-predictor counter update path: the queued
// update record and the default index/tag widths.
`ifndef BP_BASEP_ID_LEN
`define BP_BASEP_ID_LEN 4
`endif

package bp_update_unit_pkg;

  localparam int BP_IDX_LEN = `BP_BASEP_ID_LEN;
  localparam int BP_TAG_LEN = 4;

  typedef struct packed {
    logic [BP_IDX_LEN-1:0] addr;
    logic                  taken;
    logic                  init;
  } bp_update_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Pending counter-update buffer: synchronous FIFO of bp_update_t with
// wrap-bit pointers so full and empty are distinguishable at equal indices.
module bp_update_fifo
  import bp_update_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  bp_update_t               push_data,
  input  logic                     pop,
  output bp_update_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  bp_update_t     mem_q [DEPTH];
  bp_update_t     mem_d [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    head     = mem_q[rd_ptr_q[PTR_W-1:0]];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_update_unit.sv
// Write-side companion of the branch prediction counter table: remembers the
// index of each prediction by tag, turns resolutions into queued counter
// updates and issues them after the table's clear sweep, never twice in a row
// to the same index.
module bp_update_unit
  import bp_update_unit_pkg::*;
#(
  parameter int IDX_LEN    = BP_IDX_LEN,
  parameter int TAG_LEN    = BP_TAG_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               IN_predValid,
  input  logic [TAG_LEN-1:0] IN_predTag,
  input  logic [IDX_LEN-1:0] IN_predIdx,
  input  logic               IN_predHit,
  input  logic               IN_flush,
  input  logic               IN_resValid,
  input  logic [TAG_LEN-1:0] IN_resTag,
  input  logic               IN_resTaken,
  output logic               OUT_resReady,
  output logic               OUT_dropped,
  output logic               OUT_writeEn,
  output logic [IDX_LEN-1:0] OUT_writeAddr,
  output logic               OUT_writeInit,
  output logic               OUT_writeTaken,
  output logic               OUT_warm
);

  localparam int                 NUM_TAGS  = 1 << TAG_LEN;
  localparam int                 CNT_W     = IDX_LEN + 2;
  localparam logic [CNT_W-1:0]   WARM_VAL  = CNT_W'((1 << IDX_LEN) + 1);
  localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [CNT_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [NUM_TAGS-1:0] slot_vld_q, slot_vld_d;
  logic [NUM_TAGS-1:0] slot_init_q, slot_init_d;
  logic [IDX_LEN-1:0]  slot_idx_q [NUM_TAGS];
  logic [IDX_LEN-1:0]  slot_idx_d [NUM_TAGS];

  logic                wen_q, wen_d;
  logic [IDX_LEN-1:0]  waddr_q, waddr_d;
  logic                winit_q, winit_d;
  logic                wtaken_q, wtaken_d;
  logic                dropped_q, dropped_d;

  logic                res_accept, res_hit, hazard;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PTR_W:0]      fifo_count;
  bp_update_t          push_upd, head_upd;

  assign OUT_warm       = (warm_cnt_q == WARM_VAL);
  assign OUT_resReady   = !fifo_full;
  assign OUT_dropped    = dropped_q;
  assign OUT_writeEn    = wen_q;
  assign OUT_writeAddr  = waddr_q;
  assign OUT_writeInit  = winit_q;
  assign OUT_writeTaken = wtaken_q;

  always_comb begin
    warm_cnt_d = OUT_warm ? warm_cnt_q : warm_cnt_q + CNT_W'(1);
  end

  // Resolution lookup reads the slot contents from before this edge.
  always_comb begin
    res_accept     = IN_resValid && OUT_resReady;
    res_hit        = slot_vld_q[IN_resTag];
    fifo_push      = res_accept && res_hit;
    dropped_d      = res_accept && !res_hit;
    push_upd.addr  = slot_idx_q[IN_resTag];
    push_upd.taken = IN_resTaken;
    push_upd.init  = slot_init_q[IN_resTag];
  end

  // Flush and consumption clear first so a same-cycle prediction survives.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_init_d = slot_init_q;
    slot_idx_d  = slot_idx_q;
    if (IN_flush) begin
      slot_vld_d = '0;
    end
    if (fifo_push) begin
      slot_vld_d[IN_resTag] = 1'b0;
    end
    if (IN_predValid) begin
      slot_vld_d[IN_predTag]  = 1'b1;
      slot_idx_d[IN_predTag]  = IN_predIdx;
      slot_init_d[IN_predTag] = !IN_predHit;
    end
  end

  // The table's read-modify-write is unforwarded, so a head matching the
  // write in flight waits one cycle.
  always_comb begin
    hazard   = wen_q && (head_upd.addr == waddr_q);
    fifo_pop = OUT_warm && !fifo_empty && !hazard;
    wen_d    = fifo_pop;
    waddr_d  = waddr_q;
    winit_d  = winit_q;
    wtaken_d = wtaken_q;
    if (fifo_pop) begin
      waddr_d  = head_upd.addr;
      winit_d  = head_upd.init;
      wtaken_d = head_upd.taken;
    end
  end

  bp_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_upd),
    .pop       (fifo_pop),
    .head      (head_upd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= DEPTH_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt_q <= '0;
      slot_vld_q <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      winit_q    <= 1'b0;
      wtaken_q   <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      slot_vld_q <= slot_vld_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      winit_q    <= winit_d;
      wtaken_q   <= wtaken_d;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_idx_q  <= slot_idx_d;
    slot_init_q <= slot_init_d;
  end

endmodule
